tone_rom_sequencer: RTL and testbench



---
 rtl/tone_rom_sequencer_pkg.sv | 23 ++
 rtl/tone_rom_sequencer_if.sv | 50 +++++
 rtl/tone_rom_sequencer.sv | 134 +++++++++++++
 tb/tb_tone_rom_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_rom_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_rom_sequencer_pkg
// Description : Shared definitions for the tone ROM sequencer.
//               - state_t : sequencer state encoding.
//               - c_default_last_addr : last ROM index of one period for a
//                 440 Hz tone at 48000 samples/s.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_rom_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_PRESENT_L = 3'd2,
        ST_PRESENT_R = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam int unsigned c_default_last_addr = 108;

endpackage
`default_nettype wire

// File: rtl/tone_rom_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : tone_rom_sequencer_if
// Description : Control, ROM and sample-stream signals of the tone ROM
//               sequencer.
//               master : the sequencer (drives ROM address and stream)
//               slave  : its environment (ROM, transmit FIFO, software)
//   enable_i        level; start/continue streaming
//   last_addr_i     final ROM index of one period
//   num_periods_i   periods to play, 0 = continuous
//   rom_addr_o      address to tone ROM
//   rom_q_i         ROM data, combinational from rom_addr_o
//   sample_o        sample to transmit FIFO
//   sample_valid_o  sample_o valid
//   sample_ready_i  FIFO accepts sample this cycle
//   lr_o            channel of sample_o: 0 = left, 1 = right
//   busy_o          sequencer not idle
//   done_o          one-cycle pulse when the period count completes
// Revision    : 1.0 - initial release
// ============================================================================
interface tone_rom_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 16
) ();

    logic                  enable_i;
    logic [ADDR_WIDTH-1:0] last_addr_i;
    logic [CNT_WIDTH-1:0]  num_periods_i;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0] rom_q_i;
    logic [DATA_WIDTH-1:0] sample_o;
    logic                  sample_valid_o;
    logic                  sample_ready_i;
    logic                  lr_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  enable_i, last_addr_i, num_periods_i, rom_q_i, sample_ready_i,
        output rom_addr_o, sample_o, sample_valid_o, lr_o, busy_o, done_o
    );

    modport slave (
        output enable_i, last_addr_i, num_periods_i, rom_q_i, sample_ready_i,
        input  rom_addr_o, sample_o, sample_valid_o, lr_o, busy_o, done_o
    );

endinterface
`default_nettype wire

// File: rtl/tone_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tone_rom_sequencer
// Description : Steps a combinational tone ROM from address 0 to a latched
//               last address and wraps, presenting every ROM word twice
//               (left then right) on a valid/ready stream. Runs
//               continuously or for a programmed number of periods, then
//               pulses done.
// Ports       : clk_i    system clock
//               rst_n_i  synchronous, active-low reset
//               bus      tone_rom_sequencer_if.master (control, ROM, stream)
// Revision    : 1.0 - initial release
// ============================================================================
module tone_rom_sequencer
    import tone_rom_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  wire                      clk_i,
    input  wire                      rst_n_i,
    tone_rom_sequencer_if.master     bus
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [CNT_WIDTH-1:0]  r_num_periods;
    logic [CNT_WIDTH-1:0]  r_period_cnt;
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_valid;
    logic                  r_lr;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_wrap;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_limit;

    // ">=" rather than "==" so an address can never run past the latched end.
    assign w_wrap    = (r_addr >= r_last_addr);
    // Saturating increment: continuous mode may exceed the counter range.
    assign w_cnt_inc = (r_period_cnt == '1) ? r_period_cnt
                                            : r_period_cnt + CNT_WIDTH'(1);
    assign w_limit   = w_wrap && (r_num_periods != '0)
                       && (w_cnt_inc == r_num_periods);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_last_addr   <= ADDR_WIDTH'(c_default_last_addr);
            r_num_periods <= '0;
            r_period_cnt  <= '0;
            r_sample      <= '0;
            r_valid       <= 1'b0;
            r_lr          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_addr <= '0;
                    if (bus.enable_i) begin
                        // Configuration is frozen for the whole playback;
                        // each playback counts periods from zero.
                        r_last_addr   <= bus.last_addr_i;
                        r_num_periods <= bus.num_periods_i;
                        r_period_cnt  <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_sample <= bus.rom_q_i;
                    r_valid  <= 1'b1;
                    r_lr     <= 1'b0;
                    r_state  <= ST_PRESENT_L;
                end
                ST_PRESENT_L: begin
                    if (bus.sample_ready_i) begin
                        r_lr    <= 1'b1;
                        r_state <= ST_PRESENT_R;
                    end
                end
                ST_PRESENT_R: begin
                    if (bus.sample_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_wrap) begin
                            r_addr       <= '0;
                            r_period_cnt <= w_cnt_inc;
                        end else begin
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                        // enable_i is only honoured here, so a stereo pair
                        // is never split.
                        if (w_limit) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (!bus.enable_i) begin
                            r_addr  <= '0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_period_cnt <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr_o     = r_addr;
    assign bus.sample_o       = r_sample;
    assign bus.sample_valid_o = r_valid;
    assign bus.lr_o           = r_lr;
    assign bus.busy_o         = r_busy;
    assign bus.done_o         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_rom_sequencer
// Description : Self-checking bench for tone_rom_sequencer. A queue-based
//               model lists every stereo sample the stream must deliver;
//               a monitor checks each handshake and the hold rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_rom_sequencer;

    typedef struct packed {
        logic [31:0] data;
        logic        lr;
        logic [6:0]  addr;
    } exp_t;

    logic clk;
    logic rst_n;

    tone_rom_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .CNT_WIDTH(16)) bus_if ();

    tone_rom_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .CNT_WIDTH(16)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    function automatic logic [31:0] rom_word(input logic [6:0] a);
        return {16'hBEEF, 9'd0, a};
    endfunction

    assign bus_if.rom_q_i = rom_word(bus_if.rom_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    exp_t q[$];
    exp_t hs_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Model: word i of a playback uses ROM address i mod (last+1), left then right.
    task automatic push_words(input int last, input int n);
        for (int i = 0; i < n; i++) begin
            logic [6:0] a;
            a = 7'(i % (last + 1));
            q.push_back('{data: rom_word(a), lr: 1'b0, addr: a});
            q.push_back('{data: rom_word(a), lr: 1'b1, addr: a});
        end
    endtask

    // Monitor: mid-cycle sampling
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_done  = 1'b0;
    logic [31:0] prev_sample = '0;
    logic        prev_lr = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 64'(bus_if.sample_valid_o), 64'd1);
                chk("hold_sample", 64'(bus_if.sample_o), 64'(prev_sample));
                chk("hold_lr", 64'(bus_if.lr_o), 64'(prev_lr));
            end
            if (bus_if.done_o) begin
                done_cnt++;
                if (prev_done) fail_note("done_pulse_width");
            end
            if (bus_if.sample_valid_o && bus_if.sample_ready_i) begin
                hs_cnt++;
                hs_log.push_back('{data: bus_if.sample_o, lr: bus_if.lr_o, addr: bus_if.rom_addr_o});
                if (q.size() == 0) begin
                    fail_note("unexpected_handshake");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("hs_sample", 64'(bus_if.sample_o), 64'(e.data));
                    chk("hs_lr", 64'(bus_if.lr_o), 64'(e.lr));
                    chk("hs_addr", 64'(bus_if.rom_addr_o), 64'(e.addr));
                end
            end
            prev_valid  = bus_if.sample_valid_o;
            prev_ready  = bus_if.sample_ready_i;
            prev_sample = bus_if.sample_o;
            prev_lr     = bus_if.lr_o;
            prev_done   = bus_if.done_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (q.size() > n && k < budget) begin
            tick();
            k++;
        end
        if (q.size() > n) fail_note(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        tick();
        while (bus_if.busy_o && k < budget) begin
            tick();
            k++;
        end
        if (bus_if.busy_o) fail_note(name);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!bus_if.done_o && k < budget) begin
            tick();
            k++;
        end
        if (!bus_if.done_o) fail_note(name);
    endtask

    // Continuous playback of nwords words, stopped by dropping enable
    // right after the last left handshake.
    task automatic stream(input int last, input int nwords, input string name);
        push_words(last, nwords);
        bus_if.last_addr_i    = 7'(last);
        bus_if.num_periods_i  = 16'd0;
        bus_if.sample_ready_i = 1'b1;
        bus_if.enable_i       = 1'b1;
        wait_q(1, nwords * 3 + 20, {name, "_stream"});
        bus_if.enable_i = 1'b0;
        wait_idle(20, {name, "_idle"});
        chk({name, "_queue_left"}, 64'(q.size()), 64'd0);
        chk({name, "_addr_idle"}, 64'(bus_if.rom_addr_o), 64'd0);
    endtask

    initial begin
        int hs0;
        int d0;
        int seen;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int d0;
        int seen;
        rst_n                 = 1'b0;
        bus_if.enable_i       = 1'b0;
        bus_if.sample_ready_i = 1'b0;
        bus_if.last_addr_i    = 7'd0;
        bus_if.num_periods_i  = 16'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 64'(bus_if.sample_valid_o), 64'd0);
        chk("rst_busy", 64'(bus_if.busy_o), 64'd0);
        chk("rst_done", 64'(bus_if.done_o), 64'd0);
        chk("rst_addr", 64'(bus_if.rom_addr_o), 64'd0);
        chk("rst_sample", 64'(bus_if.sample_o), 64'd0);
        chk("rst_lr", 64'(bus_if.lr_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: last=3, two periods, ready high
        hs_log.delete();
        hs0 = hs_cnt;
        d0  = done_cnt;
        push_words(3, 8);
        bus_if.last_addr_i    = 7'd3;
        bus_if.num_periods_i  = 16'd2;
        bus_if.sample_ready_i = 1'b1;
        bus_if.enable_i       = 1'b1;
        wait_done(60, "t1_done");
        bus_if.enable_i = 1'b0;
        wait_idle(10, "t1_idle");
        repeat (3) tick();
        chk("t1_hs_count", 64'(hs_cnt - hs0), 64'd16);
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy_after", 64'(bus_if.busy_o), 64'd0);
        chk("t1_queue_left", 64'(q.size()), 64'd0);
        if (hs_log.size() >= 16) begin
            chk("t1_first", 64'({hs_log[0].data, hs_log[0].lr}), {31'd0, 32'hBEEF0000, 1'b0});
            chk("t1_word3_l", 64'({hs_log[6].data, hs_log[6].lr}), {31'd0, 32'hBEEF0003, 1'b0});
            chk("t1_p2_first", 64'({hs_log[8].data, hs_log[8].lr}), {31'd0, 32'hBEEF0000, 1'b0});
            chk("t1_last", 64'({hs_log[15].data, hs_log[15].lr}), {31'd0, 32'hBEEF0003, 1'b1});
        end else begin
            fail_note("t1_log_short");
        end

        // 2: ready low for 5 cycles during PRESENT_L
        do_reset();
        push_words(3, 1);
        bus_if.sample_ready_i = 1'b0;
        bus_if.last_addr_i    = 7'd3;
        bus_if.num_periods_i  = 16'd0;
        bus_if.enable_i       = 1'b1;
        seen = 0;
        while (!bus_if.sample_valid_o && seen < 10) begin
            tick();
            seen++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("t2_valid", 64'(bus_if.sample_valid_o), 64'd1);
            chk("t2_lr", 64'(bus_if.lr_o), 64'd0);
            chk("t2_sample", 64'(bus_if.sample_o), 64'hBEEF0000);
        end
        hs0 = hs_cnt;
        tick();
        bus_if.sample_ready_i = 1'b1;
        tick();
        bus_if.sample_ready_i = 1'b0;
        bus_if.enable_i       = 1'b0;
        repeat (3) tick();
        chk("t2_one_accept", 64'(hs_cnt - hs0), 64'd1);
        chk("t2_right_valid", 64'(bus_if.sample_valid_o), 64'd1);
        chk("t2_right_lr", 64'(bus_if.lr_o), 64'd1);
        bus_if.sample_ready_i = 1'b1;
        wait_idle(10, "t2_idle");
        chk("t2_queue_left", 64'(q.size()), 64'd0);

        // 3 + 4: last=108 continuous, 400 words, enable dropped after last left
        do_reset();
        hs0 = hs_cnt;
        d0  = done_cnt;
        stream(108, 400, "t3");
        chk("t3_hs_count", 64'(hs_cnt - hs0), 64'd800);
        chk("t3_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_valid_idle", 64'(bus_if.sample_valid_o), 64'd0);
        seen = 0;
        repeat (8) begin
            tick();
            if (bus_if.sample_valid_o) seen++;
        end
        chk("t4_no_further_valid", 64'(seen), 64'd0);

        // 5: last_addr changed 3 -> 10 mid-stream, takes effect only after IDLE
        do_reset();
        push_words(3, 10);
        bus_if.last_addr_i    = 7'd3;
        bus_if.num_periods_i  = 16'd0;
        bus_if.sample_ready_i = 1'b1;
        bus_if.enable_i       = 1'b1;
        wait_q(12, 60, "t5_mid");
        bus_if.last_addr_i = 7'd10;
        wait_q(1, 60, "t5_end");
        bus_if.enable_i = 1'b0;
        wait_idle(10, "t5_idle");
        chk("t5_queue_left", 64'(q.size()), 64'd0);
        stream(10, 12, "t5b");

        // 7: last_addr=0, three periods -> each pair is one period
        do_reset();
        hs0 = hs_cnt;
        d0  = done_cnt;
        push_words(0, 3);
        bus_if.last_addr_i    = 7'd0;
        bus_if.num_periods_i  = 16'd3;
        bus_if.sample_ready_i = 1'b1;
        bus_if.enable_i       = 1'b1;
        wait_done(30, "t7_done");
        bus_if.enable_i = 1'b0;
        wait_idle(10, "t7_idle");
        chk("t7_hs_count", 64'(hs_cnt - hs0), 64'd6);
        chk("t7_done_count", 64'(done_cnt - d0), 64'd1);

        // 8: last_addr=127 wraps 127 -> 0
        do_reset();
        stream(127, 130, "t8");

        // 6: reset during PRESENT_R with ready low
        do_reset();
        d0 = done_cnt;
        push_words(3, 1);
        bus_if.last_addr_i    = 7'd3;
        bus_if.num_periods_i  = 16'd1;
        bus_if.sample_ready_i = 1'b1;
        bus_if.enable_i       = 1'b1;
        wait_q(1, 20, "t6_left");
        bus_if.sample_ready_i = 1'b0;
        repeat (2) tick();
        chk("t6_pre_valid", 64'(bus_if.sample_valid_o), 64'd1);
        rst_n           = 1'b0;
        bus_if.enable_i = 1'b0;
        tick();
        chk("t6_valid", 64'(bus_if.sample_valid_o), 64'd0);
        chk("t6_addr", 64'(bus_if.rom_addr_o), 64'd0);
        chk("t6_busy", 64'(bus_if.busy_o), 64'd0);
        chk("t6_done", 64'(bus_if.done_o), 64'd0);
        rst_n = 1'b1;
        q.delete();
        repeat (5) tick();
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
